// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch-resolve controller, also used by the fetch
// and top-level pipeline: FSM state encoding and default widths.
package branch_resolve_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } brc_state_e;

    localparam int BRC_ADDR_W = 10;
    localparam int BRC_CNT_W  = 16;
    localparam int BRC_SC_W   = 3;

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter that adds 0, 1 or 2 per cycle and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d, count_q;
    logic [WIDTH:0]   sum;

    // The extra sum bit is set exactly when the increment would pass all-ones.
    always_comb begin
        sum     = {1'b0, count_q} + {{(WIDTH-1){1'b0}}, inc};
        count_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves both MEM-stage branch slots: redirects fetch, flushes the front end,
// trains the predictor and keeps saturating branch/mispredict statistics.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int ADDR_W     = BRC_ADDR_W,
    parameter int SHADOW_CYC = 1,
    parameter int CNT_W      = BRC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br1_valid,
    input  logic              br1_taken,
    input  logic              br1_pred,
    input  logic [ADDR_W-1:0] br1_target,
    input  logic [ADDR_W-1:0] br1_fallthru,
    input  logic              br2_valid,
    input  logic              br2_taken,
    input  logic              br2_pred,
    input  logic [ADDR_W-1:0] br2_target,
    input  logic [ADDR_W-1:0] br2_fallthru,
    output logic              correct_en,
    output logic [ADDR_W-1:0] correction,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic              squash2_MEM,
    output logic              squash_MEM,
    output logic              upd1_en,
    output logic [ADDR_W-1:0] upd1_pc,
    output logic              upd1_taken,
    output logic              upd2_en,
    output logic [ADDR_W-1:0] upd2_pc,
    output logic              upd2_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    brc_state_e           state_d, state_q;
    logic [BRC_SC_W-1:0]  sc_d, sc_q;
    logic                 mp1, mp2;
    logic [1:0]           br_inc, mp_inc;

    // Slot 1 is older, so its mispredict hides anything slot 2 reports.
    assign mp1 = br1_valid & (br1_taken != br1_pred);
    assign mp2 = br2_valid & (br2_taken != br2_pred) & ~mp1;

    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        correct_en  = 1'b0;
        correction  = '0;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        squash2_MEM = 1'b0;
        squash_MEM  = 1'b0;
        upd1_en     = 1'b0;
        upd1_pc     = '0;
        upd1_taken  = 1'b0;
        upd2_en     = 1'b0;
        upd2_pc     = '0;
        upd2_taken  = 1'b0;
        br_inc      = 2'd0;
        mp_inc      = 2'd0;

        if (rst) begin
            case (state_q)
                RUN: begin
                    upd1_en    = br1_valid;
                    upd1_pc    = br1_fallthru - ADDR_W'(1);
                    upd1_taken = br1_taken;
                    upd2_en    = br2_valid & ~mp1;
                    upd2_pc    = br2_fallthru - ADDR_W'(1);
                    upd2_taken = br2_taken;
                    br_inc     = {1'b0, br1_valid} + {1'b0, br2_valid & ~mp1};
                    mp_inc     = {1'b0, mp1 | mp2};

                    if (mp1) begin
                        correct_en  = 1'b1;
                        correction  = br1_taken ? br1_target : br1_fallthru;
                        flush_IFID  = 1'b1;
                        flush_IDEX  = 1'b1;
                        squash2_MEM = 1'b1;
                    end else if (mp2) begin
                        correct_en  = 1'b1;
                        correction  = br2_taken ? br2_target : br2_fallthru;
                        flush_IFID  = 1'b1;
                        flush_IDEX  = 1'b1;
                    end

                    if (mp1 | mp2) begin
                        state_d = SHADOW;
                        sc_d    = BRC_SC_W'(SHADOW_CYC - 1);
                    end
                end
                SHADOW: begin
                    squash_MEM  = 1'b1;
                    squash2_MEM = 1'b1;
                    if (sc_q == '0) begin
                        state_d = RUN;
                    end else begin
                        sc_d = sc_q - BRC_SC_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    sc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_inc),
        .count (branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mp_inc),
        .count (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed plus randomized bench for branch_resolve_ctrl, checked against a
// cycle-level behavioural model of redirect, shadow window and statistics.
module tb_branch_resolve_ctrl;

    localparam int AW   = 10;
    localparam int SC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          br1_valid, br1_taken, br1_pred;
    logic [AW-1:0] br1_target, br1_fallthru;
    logic          br2_valid, br2_taken, br2_pred;
    logic [AW-1:0] br2_target, br2_fallthru;
    logic          correct_en, flush_IFID, flush_IDEX, squash2_MEM, squash_MEM;
    logic [AW-1:0] correction, upd1_pc, upd2_pc;
    logic          upd1_en, upd1_taken, upd2_en, upd2_taken;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: shadow cycles still to be ignored, and the two statistics.
    int m_shadow;
    int m_branch;
    int m_mispred;

    branch_resolve_ctrl #(.ADDR_W(AW), .SHADOW_CYC(SC), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .br1_valid    (br1_valid),
        .br1_taken    (br1_taken),
        .br1_pred     (br1_pred),
        .br1_target   (br1_target),
        .br1_fallthru (br1_fallthru),
        .br2_valid    (br2_valid),
        .br2_taken    (br2_taken),
        .br2_pred     (br2_pred),
        .br2_target   (br2_target),
        .br2_fallthru (br2_fallthru),
        .correct_en   (correct_en),
        .correction   (correction),
        .flush_IFID   (flush_IFID),
        .flush_IDEX   (flush_IDEX),
        .squash2_MEM  (squash2_MEM),
        .squash_MEM   (squash_MEM),
        .upd1_en      (upd1_en),
        .upd1_pc      (upd1_pc),
        .upd1_taken   (upd1_taken),
        .upd2_en      (upd2_en),
        .upd2_pc      (upd2_pc),
        .upd2_taken   (upd2_taken),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pcMinusOne(input int fallthru);
        return (fallthru + (1 << AW) - 1) % (1 << AW);
    endfunction

    function automatic int satAdd(input int cur, input int add);
        return (cur + add > CMAX) ? CMAX : cur + add;
    endfunction

    task automatic applyStimulus(input logic v1, input logic t1, input logic p1,
                                 input logic [AW-1:0] tg1, input logic [AW-1:0] ft1,
                                 input logic v2, input logic t2, input logic p2,
                                 input logic [AW-1:0] tg2, input logic [AW-1:0] ft2);
        br1_valid = v1; br1_taken = t1; br1_pred = p1; br1_target = tg1; br1_fallthru = ft1;
        br2_valid = v2; br2_taken = t2; br2_pred = p2; br2_target = tg2; br2_fallthru = ft2;
        #2;
    endtask

    task automatic checkOutput();
        bit e_ce, e_fl, e_sq2, e_sq, e_u1, e_u2, bad1, bad2;
        int e_corr;
        e_ce = 0; e_fl = 0; e_sq2 = 0; e_sq = 0; e_u1 = 0; e_u2 = 0; e_corr = 0;
        if (rst === 1'b1) begin
            if (m_shadow > 0) begin
                e_sq  = 1;
                e_sq2 = 1;
            end else begin
                bad1 = br1_valid && (br1_taken != br1_pred);
                bad2 = br2_valid && (br2_taken != br2_pred);
                e_u1 = br1_valid;
                e_u2 = br2_valid && !bad1;
                if (bad1) begin
                    e_ce = 1; e_fl = 1; e_sq2 = 1;
                    e_corr = br1_taken ? int'(br1_target) : int'(br1_fallthru);
                end else if (bad2) begin
                    e_ce = 1; e_fl = 1;
                    e_corr = br2_taken ? int'(br2_target) : int'(br2_fallthru);
                end
            end
        end
        compareValue("correct_en", correct_en, e_ce);
        compareValue("correction", correction, e_corr);
        compareValue("flush_IFID", flush_IFID, e_fl);
        compareValue("flush_IDEX", flush_IDEX, e_fl);
        compareValue("squash2_MEM", squash2_MEM, e_sq2);
        compareValue("squash_MEM", squash_MEM, e_sq);
        compareValue("upd1_en", upd1_en, e_u1);
        compareValue("upd2_en", upd2_en, e_u2);
        if (e_u1) begin
            compareValue("upd1_pc", upd1_pc, pcMinusOne(int'(br1_fallthru)));
            compareValue("upd1_taken", upd1_taken, br1_taken);
        end
        if (e_u2) begin
            compareValue("upd2_pc", upd2_pc, pcMinusOne(int'(br2_fallthru)));
            compareValue("upd2_taken", upd2_taken, br2_taken);
        end
        compareValue("branch_cnt", branch_cnt, m_branch);
        compareValue("mispred_cnt", mispred_cnt, m_mispred);
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic tick();
        bit bad1, bad2;
        int nb;
        @(posedge clk);
        #1;
        if (rst !== 1'b1) begin
            m_shadow = 0; m_branch = 0; m_mispred = 0;
        end else if (m_shadow > 0) begin
            m_shadow--;
        end else begin
            bad1 = br1_valid && (br1_taken != br1_pred);
            bad2 = br2_valid && (br2_taken != br2_pred) && !bad1;
            nb = int'(br1_valid) + ((br2_valid && !bad1) ? 1 : 0);
            m_branch = satAdd(m_branch, nb);
            if (bad1 || bad2) begin
                m_mispred = satAdd(m_mispred, 1);
                m_shadow  = SC;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
            checkOutput();
            tick();
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        m_shadow = 0; m_branch = 0; m_mispred = 0;
        idle(2);
        rst = 1'b1;
    endtask

    initial begin
        int pulses;
        logic v1, t1, v2, t2;

        rst = 1'b0;
        m_shadow = 0; m_branch = 0; m_mispred = 0;
        @(posedge clk);
        #1;

        $display("[TB] reset hold and release");
        applyStimulus(1, 1, 0, 10'h2A5, 10'h010, 0, 0, 0, '0, '0);
        checkOutput();
        compareValue("rst_correct_en", correct_en, 0);
        tick();
        checkOutput();
        rst = 1'b1;
        #1;
        checkOutput();
        compareValue("rel_correct_en", correct_en, 1);
        compareValue("rel_correction", correction, 10'h2A5);
        tick();
        idle(SC);

        $display("[TB] slot-1 mispredict");
        doReset();
        applyStimulus(1, 0, 1, 10'h300, 10'h045, 1, 1, 0, 10'h111, 10'h222);
        checkOutput();
        compareValue("s1_correction", correction, 10'h045);
        compareValue("s1_flush_IFID", flush_IFID, 1);
        compareValue("s1_flush_IDEX", flush_IDEX, 1);
        compareValue("s1_squash2", squash2_MEM, 1);
        compareValue("s1_upd2_en", upd2_en, 0);
        tick();
        applyStimulus(1, 0, 1, 10'h300, 10'h045, 1, 1, 0, 10'h111, 10'h222);
        checkOutput();
        compareValue("s1_shadow_squash", squash_MEM, 1);
        compareValue("s1_shadow_ce", correct_en, 0);
        compareValue("s1_mispred_cnt", mispred_cnt, 1);
        compareValue("s1_branch_cnt", branch_cnt, 1);
        tick();
        idle(SC - 1);

        $display("[TB] slot-2 mispredict");
        doReset();
        applyStimulus(1, 1, 1, 10'h050, 10'h011, 1, 1, 0, 10'h120, 10'h012);
        checkOutput();
        compareValue("s2_correction", correction, 10'h120);
        compareValue("s2_squash2", squash2_MEM, 0);
        compareValue("s2_upd1_en", upd1_en, 1);
        compareValue("s2_upd2_en", upd2_en, 1);
        tick();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        compareValue("s2_branch_cnt", branch_cnt, 2);
        checkOutput();
        tick();
        idle(SC - 1);

        $display("[TB] shadow window");
        doReset();
        pulses = 0;
        for (int i = 0; i < SC + 1; i++) begin
            applyStimulus(1, 1, 0, 10'h0AA, 10'h0BB, 1, 0, 1, 10'h0CC, 10'h0DD);
            checkOutput();
            if (correct_en === 1'b1) pulses++;
            tick();
        end
        compareValue("sh_one_pulse", pulses, 1);
        applyStimulus(1, 1, 0, 10'h0AA, 10'h0BB, 1, 0, 1, 10'h0CC, 10'h0DD);
        checkOutput();
        compareValue("sh_run_again", correct_en, 1);
        compareValue("sh_correction", correction, 10'h0AA);
        tick();
        idle(SC);

        $display("[TB] counter saturation");
        doReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 1, 1, 10'h001, 10'h002, 1, 0, 0, 10'h003, 10'h004);
            checkOutput();
            tick();
        end
        applyStimulus(1, 1, 1, 10'h001, 10'h002, 1, 0, 0, 10'h003, 10'h004);
        compareValue("sat_at_14", branch_cnt, 14);
        tick();
        applyStimulus(1, 1, 1, 10'h001, 10'h002, 1, 0, 0, 10'h003, 10'h004);
        compareValue("sat_at_15", branch_cnt, 15);
        tick();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        compareValue("sat_hold_15", branch_cnt, 15);
        checkOutput();
        tick();

        $display("[TB] pc wrap");
        doReset();
        applyStimulus(1, 1, 1, 10'h001, 10'h000, 1, 0, 0, 10'h002, 10'h000);
        compareValue("wrap_upd1_pc", upd1_pc, 10'h3FF);
        compareValue("wrap_upd2_pc", upd2_pc, 10'h3FF);
        checkOutput();
        tick();

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) doReset();
            v1 = 1'($urandom_range(0, 1));
            t1 = 1'($urandom_range(0, 1));
            v2 = 1'($urandom_range(0, 1));
            t2 = 1'($urandom_range(0, 1));
            applyStimulus(v1, t1, ($urandom_range(0, 3) == 0) ? ~t1 : t1,
                          AW'($urandom), AW'($urandom),
                          v2, t2, ($urandom_range(0, 3) == 0) ? ~t2 : t2,
                          AW'($urandom), AW'($urandom));
            checkOutput();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
